updown_mod_counter: RTL

Parametrised up/down modulo counter, the successor to the lab's fixed 0–7 ascending/descending counter. It adds:
- configurable width and count range;
- up, down, ping-pong and hold modes;
- wrap or saturate at the limits;
- synchronous load and count enable;
- registered wrap and limit flags, for cascading into display drivers and timing chains.

---
 rtl/updown_mod_counter_pkg.sv | 24 ++
 rtl/updown_mod_counter_if.sv | 26 ++
 rtl/updown_mod_counter_step.sv | 76 +++++++
 rtl/updown_mod_counter.sv | 73 +++++++
 4 files changed

// File: rtl/updown_mod_counter_pkg.sv
// Shared types and helpers for the up/down modulo counter.
// Mode encodings, ping-pong direction states and the load clamp.
package updown_mod_counter_pkg;

    typedef enum logic [1:0] {
        MODE_DOWN = 2'b00,
        MODE_UP   = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    typedef enum logic {
        PP_DOWN = 1'b0,
        PP_UP   = 1'b1
    } pp_state_e;

    // Signed compare avoids constant-unsigned compares when lo is 0.
    function automatic int clamp_val(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of the up/down modulo counter.
// master drives controls and observes the count; slave is the counter.
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic             saturate;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             dir;
    logic             wrap;
    logic             at_max;
    logic             at_min;

    modport master (
        output en, mode, saturate, load, load_val,
        input  q, dir, wrap, at_max, at_min
    );

    modport slave (
        input  en, mode, saturate, load, load_val,
        output q, dir, wrap, at_max, at_min
    );
endinterface

// File: rtl/updown_mod_counter_step.sv
// Combinational next-state logic: limits, wrap/saturate and direction.
// q is always in range, so limit detection uses equality only.
module counter_step
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 7
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_dir,
    input  logic [1:0]       i_mode,
    input  logic             i_saturate,
    output logic [WIDTH-1:0] o_next_q,
    output logic             o_next_dir,
    output logic             o_wrap_evt
);

    localparam logic [WIDTH-1:0] L_MIN = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);

    logic w_at_max;
    logic w_at_min;

    assign w_at_max = (i_q == L_MAX);
    assign w_at_min = (i_q == L_MIN);

    always_comb begin
        o_next_q   = i_q;
        o_next_dir = i_dir;
        o_wrap_evt = 1'b0;
        unique case (i_mode)
            MODE_UP: begin
                if (!w_at_max) begin
                    o_next_q = i_q + L_ONE;
                end else if (!i_saturate) begin
                    o_next_q   = L_MIN;
                    o_wrap_evt = 1'b1;
                end
            end
            MODE_DOWN: begin
                if (!w_at_min) begin
                    o_next_q = i_q - L_ONE;
                end else if (!i_saturate) begin
                    o_next_q   = L_MAX;
                    o_wrap_evt = 1'b1;
                end
            end
            MODE_PING: begin
                // Reversal steps straight to the neighbour so no value repeats.
                if (i_dir == PP_UP) begin
                    if (!w_at_max) begin
                        o_next_q = i_q + L_ONE;
                    end else begin
                        o_next_q   = L_MAX - L_ONE;
                        o_next_dir = PP_DOWN;
                        o_wrap_evt = 1'b1;
                    end
                end else begin
                    if (!w_at_min) begin
                        o_next_q = i_q - L_ONE;
                    end else begin
                        o_next_q   = L_MIN + L_ONE;
                        o_next_dir = PP_UP;
                        o_wrap_evt = 1'b1;
                    end
                end
            end
            MODE_HOLD: begin
                o_next_q = i_q;
            end
        endcase
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down/ping-pong modulo counter with wrap and limit flags.
// Top level holds the registers, the load clamp and the update priority.
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 7
) (
    input  logic               clock,
    input  logic               reset,
    updown_mod_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] L_MIN = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_VAL);

    if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL &&
          longint'(MAX_VAL) <= (longint'(1) << WIDTH) - 1)) begin : g_bad_params
        $error("updown_mod_counter: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
    end

    logic [WIDTH-1:0] r_q;
    pp_state_e        r_dir;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next_q;
    logic             w_next_dir;
    logic             w_wrap_evt;
    logic [WIDTH-1:0] w_load_q;
    logic             w_count;

    counter_step #(
        .WIDTH   (WIDTH),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL)
    ) u_step (
        .i_q        (r_q),
        .i_dir      (r_dir),
        .i_mode     (bus.mode),
        .i_saturate (bus.saturate),
        .o_next_q   (w_next_q),
        .o_next_dir (w_next_dir),
        .o_wrap_evt (w_wrap_evt)
    );

    assign w_load_q = WIDTH'(clamp_val(int'(bus.load_val), MIN_VAL, MAX_VAL));
    assign w_count  = bus.en && (bus.mode != MODE_HOLD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q    <= L_MIN;
            r_dir  <= PP_UP;
            r_wrap <= 1'b0;
        end else if (bus.load) begin
            r_q    <= w_load_q;
            r_wrap <= 1'b0;
        end else if (w_count) begin
            r_q    <= w_next_q;
            r_dir  <= pp_state_e'(w_next_dir);
            r_wrap <= w_wrap_evt;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign bus.q      = r_q;
    assign bus.dir    = r_dir;
    assign bus.wrap   = r_wrap;
    assign bus.at_max = (r_q == L_MAX);
    assign bus.at_min = (r_q == L_MIN);

endmodule
